// File: rtl/irq_enc_pkg.sv
// Shared constants and helpers for the irq_encoder8 request encoder.
package irq_enc_pkg;
   localparam int N  = 8;
   localparam int IW = 3;

   localparam logic [IW-1:0] PTR_RST = 3'd7;

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder: first set bit at or after start, wrapping modulo 8.
module prio_enc8
   import irq_enc_pkg::*;
(
   input  logic [N-1:0]  c,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] w_pos;

   always_comb begin
      idx   = '0;
      any   = 1'b0;
      w_pos = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = start + IW'(k);
         if (!any && c[w_pos]) begin
            idx = w_pos;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_encoder8.sv
// Sequential 8-to-3 request encoder with valid/ready output slot.
// Define IRQ_ENC_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module irq_encoder8
   import irq_enc_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          clr,
   input  logic          ready_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o,
   output logic [N-1:0]  pend_o
);

   logic [N-1:0]  r_pend;
   logic [IW-1:0] r_idx;
   logic          r_valid;

   logic          w_free;
   logic [N-1:0]  w_c;
   logic [IW-1:0] w_start;
   logic [IW-1:0] w_gnt;
   logic          w_any;

   assign w_free = !r_valid || ready_i;
   assign w_c    = r_pend | req;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
   logic [IW-1:0] r_ptr;

   // Search begins just past the last granted source so every source gets a turn.
   assign w_start = r_ptr + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= PTR_RST;
      end else if (clr) begin
         r_ptr <= PTR_RST;
      end else if (w_free && w_any) begin
         r_ptr <= w_gnt;
      end
   end
`else
   assign w_start = '0;
`endif

   prio_enc8 u_prio (
      .c     (w_c),
      .start (w_start),
      .idx   (w_gnt),
      .any   (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend  <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
      end else if (clr) begin
         r_pend  <= '0;
         r_valid <= 1'b0;
      end else if (w_free) begin
         if (w_any) begin
            r_idx   <= w_gnt;
            r_valid <= 1'b1;
            r_pend  <= w_c & ~onehot(w_gnt);
         end else begin
            r_valid <= 1'b0;
            r_pend  <= '0;
         end
      end else begin
         // Slot stalled: keep the held index, just accumulate new requests.
         r_pend <= r_pend | req;
      end
   end

   assign idx_o   = r_idx;
   assign valid_o = r_valid;
   assign pend_o  = r_pend;

endmodule
